mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single 32-bit AXI4-lite master port between the instruction-fetch requester (read-only) and the load/store requester.
- Sequences each transaction through the AR/R or AW/W/B channels and returns one response pulse to the granted requester.
- Sits between the core state machine and the memory interconnect, and replaces ad-hoc channel handling inside the core.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending before fetch is forced.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch request; held with i_req_addr until i_rsp_valid
i_req_addr  in  32  fetch address
d_req_valid  in  1  data request; held with its payload until d_rsp_valid
d_req_write  in  1  1 = store, 0 = load
d_req_addr  in  32  data address
d_req_wdata  in  32  store data
d_req_wstrb  in  4  store byte enables
i_rsp_valid  out  1  one-cycle fetch completion
d_rsp_valid  out  1  one-cycle data completion
rsp_rdata  out  32  read data; valid with either rsp_valid
rsp_err  out  1  SLVERR/DECERR seen; valid with either rsp_valid
awvalid  out  1  write address valid
awready  in  1  write address ready
awaddr  out  32  write address
wvalid  out  1  write data valid
wready  in  1  write data ready
wdata  out  32  write data
wstrb  out  4  write strobes
bvalid  in  1  write response valid
bready  out  1  write response ready
bresp  in  2  write response
arvalid  out  1  read address valid
arready  in  1  read address ready
araddr  out  32  read address
arprot  out  3  3'b101 for fetch, 3'b000 for data
rvalid  in  1  read data valid
rready  out  1  read data ready
rdata  in  32  read data
rresp  in  2  read response

Behaviour:
- All outputs are registered. awprot is not a port; the top level ties it to 3'b000.
- Reset (synchronous, active-high) sets: state IDLE; every valid/ready/rsp output 0; rsp_rdata, araddr, awaddr, wdata = 0; wstrb = 0; rsp_err = 0; arprot = 3'b101; starve counter = 0.
- Reset mid-transaction abandons the transaction: outputs drop on the next edge and no rsp_valid is issued. The slave shares the same reset.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RESP. Exactly one transaction is outstanding at a time.
- IDLE grant rules:
  - If only one requester is valid, grant it.
  - If both are valid, grant data, unless the starve counter equals STARVE_LIMIT; then grant fetch.
  - A granted read latches the address and prot into araddr/arprot, asserts arvalid and goes to RD_ADDR.
  - A granted write loads awaddr, wdata and wstrb, asserts awvalid and wvalid, and goes to WR_ADDR.
- Starve counter: increments on each data grant while i_req_valid = 1. It clears on a fetch grant or in any cycle with i_req_valid = 0. It saturates at STARVE_LIMIT.
- RD_ADDR: hold arvalid until arvalid & arready. Then drop arvalid, assert rready and go to RD_DATA.
- RD_DATA: on rvalid & rready, drop rready, capture the response and go to RESP.
  - rresp 00 (OKAY) or 01 (EXOKAY): rsp_rdata = rdata, rsp_err = 0.
  - rresp 10 or 11: rsp_rdata = 0, rsp_err = 1.
- WR_ADDR: awvalid and wvalid each drop independently on their own handshake, in either order or in the same cycle. When both are done, assert bready and go to WR_RESP.
- WR_RESP: on bvalid & bready, drop bready and go to RESP.
  - rsp_err = (bresp[1] == 1).
  - rsp_rdata = 0.
- RESP: pulse the granted requester's rsp_valid for exactly one cycle, then return to IDLE.
- Requesters deassert valid on the edge after rsp_valid, so IDLE never re-grants a completed request.
- Latency with a zero-wait slave: request sampled at edge 0; arvalid in cycle 1; rready in cycle 2; rsp_valid in cycle 3. A write takes the same 3 cycles.
- d_req_wstrb = 0 is issued to the bus unchanged.
- Request changes while not in IDLE are ignored and flagged by a bench assertion as a protocol violation.

Decomposition:
- Package riscv_mem_pkg holds:
  - resp codes RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - INST_PROT = 3'b101 and DATA_PROT = 3'b000;
  - the arbiter state enum.
- Single module; no sub-module is warranted.

Test Plan:
1. Fetch read at 0x0000_0004, zero-wait slave, rdata 0x0000_0013, rresp 00 → araddr = 4, arprot = 101, i_rsp_valid in cycle 3, rsp_rdata = 0x13, rsp_err = 0.
2. Store to 0x100, wdata 0xDEADBEEF, wstrb 1111; awready delayed 2 cycles, wready immediate → wvalid high 1 cycle, awvalid high 3 cycles, bready only after both handshakes; bresp 00 → d_rsp_valid with rsp_err = 0.
3. Both requesters valid in IDLE → data load granted first (arprot 000), fetch granted next; with STARVE_LIMIT = 4 and both held continuously, fetch is granted after exactly 4 data grants.
4. rresp = 10 on a load → rsp_err = 1, rsp_rdata = 0; bresp = 11 on a store → rsp_err = 1.
5. reset asserted for 1 cycle during RD_DATA → arvalid and rready are 0 on the next cycle, no rsp_valid; a following fetch completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core's memory port: AXI response codes,
// protection encodings for instruction/data traffic, and the arbiter state set.
package riscv_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Privileged+instruction for fetches, plain unprivileged data otherwise.
   localparam logic [2:0] INST_PROT = 3'b101;
   localparam logic [2:0] DATA_PROT = 3'b000;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_RESP,
      RESP
   } arb_state_t;

   // Both error codes carry bit 1; OKAY and EXOKAY are successful.
   function automatic logic is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// AXI4-lite master port bundle between the arbiter (master) and the
// memory interconnect (slave).
interface mem_port_arbiter_if;

   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one AXI4-lite master port between instruction fetch (read-only)
// and load/store. One transaction in flight; data has priority, but fetch
// is forced after STARVE_LIMIT consecutive data grants while it waits.
// Every output comes straight from a flop.
module mem_port_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        i_req_valid,
   input  logic [31:0] i_req_addr,

   input  logic        d_req_valid,
   input  logic        d_req_write,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wstrb,

   output logic        i_rsp_valid,
   output logic        d_rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,

   mem_port_arbiter_if.master bus
);

   localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   // All registered outputs plus the record of who owns the transaction.
   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic [2:0]  arprot;
      logic        rready;
      logic        awvalid;
      logic [31:0] awaddr;
      logic        wvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        bready;
      logic        i_rsp_valid;
      logic        d_rsp_valid;
      logic [31:0] rsp_rdata;
      logic        rsp_err;
      logic        fetch;
   } regs_t;

   localparam regs_t REGS_RESET = '{arprot: INST_PROT, default: '0};

   arb_state_t       state_q, state_n;
   regs_t            regs_q, regs_n;
   logic [CNT_W-1:0] starve_q, starve_n;

   // State, output and starvation registers; reset abandons any transaction.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         regs_q   <= REGS_RESET;
         starve_q <= '0;
      end else begin
         state_q  <= state_n;
         regs_q   <= regs_n;
         starve_q <= starve_n;
      end
   end

   // Grant decision, channel sequencing and response capture.
   always_comb begin
      // NOTE: defaults first, so no path leaves a variable unassigned (no latch).
      state_n            = state_q;
      regs_n             = regs_q;
      starve_n           = starve_q;
      regs_n.i_rsp_valid = 1'b0;
      regs_n.d_rsp_valid = 1'b0;

      // A fetch that is not waiting cannot be starved.
      if (!i_req_valid) begin
         starve_n = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (i_req_valid && (!d_req_valid || starve_q == LIMIT)) begin
               starve_n       = '0;
               regs_n.fetch   = 1'b1;
               regs_n.araddr  = i_req_addr;
               regs_n.arprot  = INST_PROT;
               regs_n.arvalid = 1'b1;
               state_n        = RD_ADDR;
            end else if (d_req_valid) begin
               if (i_req_valid && starve_q < LIMIT) begin
                  starve_n = starve_q + CNT_W'(1);
               end
               regs_n.fetch = 1'b0;
               if (d_req_write) begin
                  regs_n.awaddr  = d_req_addr;
                  regs_n.wdata   = d_req_wdata;
                  regs_n.wstrb   = d_req_wstrb;
                  regs_n.awvalid = 1'b1;
                  regs_n.wvalid  = 1'b1;
                  state_n        = WR_ADDR;
               end else begin
                  regs_n.araddr  = d_req_addr;
                  regs_n.arprot  = DATA_PROT;
                  regs_n.arvalid = 1'b1;
                  state_n        = RD_ADDR;
               end
            end
         end

         RD_ADDR: begin
            if (regs_q.arvalid && bus.arready) begin
               regs_n.arvalid = 1'b0;
               regs_n.rready  = 1'b1;
               state_n        = RD_DATA;
            end
         end

         RD_DATA: begin
            if (regs_q.rready && bus.rvalid) begin
               regs_n.rready      = 1'b0;
               regs_n.rsp_err     = is_err(bus.rresp);
               regs_n.rsp_rdata   = is_err(bus.rresp) ? '0 : bus.rdata;
               regs_n.i_rsp_valid = regs_q.fetch;
               regs_n.d_rsp_valid = !regs_q.fetch;
               state_n            = RESP;
            end
         end

         WR_ADDR: begin
            // Address and data channels complete independently.
            if (regs_q.awvalid && bus.awready) begin
               regs_n.awvalid = 1'b0;
            end
            if (regs_q.wvalid && bus.wready) begin
               regs_n.wvalid = 1'b0;
            end
            if (!regs_n.awvalid && !regs_n.wvalid) begin
               regs_n.bready = 1'b1;
               state_n       = WR_RESP;
            end
         end

         WR_RESP: begin
            if (regs_q.bready && bus.bvalid) begin
               regs_n.bready      = 1'b0;
               regs_n.rsp_err     = bus.bresp[1];
               regs_n.rsp_rdata   = '0;
               regs_n.i_rsp_valid = regs_q.fetch;
               regs_n.d_rsp_valid = !regs_q.fetch;
               state_n            = RESP;
            end
         end

         RESP: begin
            // rsp_valid is high for this single cycle; defaults clear it.
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.arvalid = regs_q.arvalid;
   assign bus.araddr  = regs_q.araddr;
   assign bus.arprot  = regs_q.arprot;
   assign bus.rready  = regs_q.rready;
   assign bus.awvalid = regs_q.awvalid;
   assign bus.awaddr  = regs_q.awaddr;
   assign bus.awprot  = DATA_PROT;
   assign bus.wvalid  = regs_q.wvalid;
   assign bus.wdata   = regs_q.wdata;
   assign bus.wstrb   = regs_q.wstrb;
   assign bus.bready  = regs_q.bready;

   assign i_rsp_valid = regs_q.i_rsp_valid;
   assign d_rsp_valid = regs_q.d_rsp_valid;
   assign rsp_rdata   = regs_q.rsp_rdata;
   assign rsp_err     = regs_q.rsp_err;

endmodule
